// File: rtl/ca_rx_align_ctrl.sv
// Alignment sequencer for a bank of RX alignment FIFOs: fill wait, per-channel
// marker hunt, lockstep pop with marker/skew monitoring and a sticky error state.
module ca_rx_align_ctrl #(
  parameter int NUM_CHANNELS = 24,
  parameter int FILL_DLY     = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                    com_clk,
  input  logic                    rst_com_n,
  input  logic                    align_en,
  input  logic [NUM_CHANNELS-1:0] rd_empty,
  input  logic [NUM_CHANNELS-1:0] rx_marker,
  input  logic                    rd_en,
  output logic [NUM_CHANNELS-1:0] fifo_pop,
  output logic                    align_done,
  output logic                    align_err,
  output logic                    rx_valid,
  output logic [15:0]             hunt_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_HUNT,
    ST_LOCKED,
    ST_ERR
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  fill_cnt_reg, fill_cnt_next;
  logic [15:0] hunt_cnt_reg, hunt_cnt_next;
  logic [3:0]  skew_cnt_reg, skew_cnt_next;
  logic        align_done_reg;
  logic        align_err_reg;

  logic [NUM_CHANNELS-1:0] held;
  logic [NUM_CHANNELS-1:0] hunt_pop;

  // A channel is held once its head word is a valid marker; others discard.
  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
      assign held[gi]     = ~rd_empty[gi] & rx_marker[gi];
      assign hunt_pop[gi] = ~rd_empty[gi] & ~rx_marker[gi];
    end
  endgenerate

  logic all_full, all_empty, skew_mixed, marker_mixed, lock_pop;

  assign all_full     = ~|rd_empty;
  assign all_empty    = &rd_empty;
  assign skew_mixed   = ~all_full & ~all_empty;
  assign marker_mixed = |rx_marker & ~&rx_marker;
  assign lock_pop     = rd_en & all_full;

  always_comb begin
    state_next    = state_reg;
    fill_cnt_next = fill_cnt_reg;
    hunt_cnt_next = hunt_cnt_reg;
    skew_cnt_next = skew_cnt_reg;
    fifo_pop      = '0;
    rx_valid      = 1'b0;
    if (!align_en) begin
      state_next    = ST_IDLE;
      fill_cnt_next = '0;
      hunt_cnt_next = '0;
      skew_cnt_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          fill_cnt_next = '0;
          hunt_cnt_next = '0;
          skew_cnt_next = '0;
          state_next    = ST_FILL;
        end
        ST_FILL: begin
          if (!all_full) begin
            fill_cnt_next = '0;
          end else if (fill_cnt_reg == 8'(FILL_DLY - 1)) begin
            fill_cnt_next = '0;
            state_next    = ST_HUNT;
          end else begin
            fill_cnt_next = fill_cnt_reg + 8'd1;
          end
        end
        ST_HUNT: begin
          fifo_pop = hunt_pop;
          if (hunt_cnt_reg != 16'hFFFF) begin
            hunt_cnt_next = hunt_cnt_reg + 16'd1;
          end
          // Lock takes priority over a timeout landing in the same cycle.
          if (&held) begin
            state_next    = ST_LOCKED;
            skew_cnt_next = '0;
          end else if (hunt_cnt_reg == 16'(TIMEOUT - 1)) begin
            state_next = ST_ERR;
          end
        end
        ST_LOCKED: begin
          if (lock_pop) begin
            fifo_pop = '1;
            rx_valid = 1'b1;
            if (marker_mixed) begin
              state_next = ST_ERR;
            end
          end
          // Mixed empties tolerated for 15 cycles; the 16th consecutive one errors.
          if (skew_mixed) begin
            if (skew_cnt_reg == 4'd15) begin
              state_next = ST_ERR;
            end else begin
              skew_cnt_next = skew_cnt_reg + 4'd1;
            end
          end else begin
            skew_cnt_next = '0;
          end
        end
        ST_ERR: begin
          state_next = ST_ERR;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge com_clk or negedge rst_com_n) begin
    if (!rst_com_n) begin
      state_reg      <= ST_IDLE;
      fill_cnt_reg   <= '0;
      hunt_cnt_reg   <= '0;
      skew_cnt_reg   <= '0;
      align_done_reg <= 1'b0;
      align_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      fill_cnt_reg   <= fill_cnt_next;
      hunt_cnt_reg   <= hunt_cnt_next;
      skew_cnt_reg   <= skew_cnt_next;
      align_done_reg <= (state_next == ST_LOCKED);
      align_err_reg  <= (state_next == ST_ERR);
    end
  end

  assign align_done = align_done_reg;
  assign align_err  = align_err_reg;
  assign hunt_cnt   = hunt_cnt_reg;

endmodule

// File: tb/tb_ca_rx_align_ctrl.sv
// Directed bench for ca_rx_align_ctrl: a per-cycle vector table for the main
// alignment flow plus hand sequences for timeout, fill restart and skew window.
module tb_ca_rx_align_ctrl;

  logic        com_clk;
  logic        rst_com_n;
  logic        align_en;
  logic [3:0]  rd_empty;
  logic [3:0]  rx_marker;
  logic        rd_en;
  logic [3:0]  fifo_pop;
  logic        align_done;
  logic        align_err;
  logic        rx_valid;
  logic [15:0] hunt_cnt;

  int checks   = 0;
  int failures = 0;

  ca_rx_align_ctrl #(
    .NUM_CHANNELS(4),
    .FILL_DLY    (4),
    .TIMEOUT     (20)
  ) dut (
    .com_clk   (com_clk),
    .rst_com_n (rst_com_n),
    .align_en  (align_en),
    .rd_empty  (rd_empty),
    .rx_marker (rx_marker),
    .rd_en     (rd_en),
    .fifo_pop  (fifo_pop),
    .align_done(align_done),
    .align_err (align_err),
    .rx_valid  (rx_valid),
    .hunt_cnt  (hunt_cnt)
  );

  initial com_clk = 1'b0;
  always #5 com_clk = ~com_clk;

  typedef struct {
    logic        en;
    logic        rd;
    logic [3:0]  empty;
    logic [3:0]  marker;
    logic [3:0]  pop;
    logic        valid;
    logic        done;
    logic        err;
    logic [15:0] hunt;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge com_clk);
    #1;
  endtask

  // Hunt with channel 2 never showing a marker; optionally lock on the last allowed cycle.
  task automatic run_hunt(input int lock_at);
    align_en = 1'b0; rd_en = 1'b0; rd_empty = 4'b0000; rx_marker = 4'b1011;
    tick();
    align_en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge com_clk);
      chk($sformatf("hunt%0d_prefill_pop%0d", lock_at, c), 16'(fifo_pop), 16'h0);
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      rx_marker = (k == lock_at) ? 4'b1111 : 4'b1011;
      @(negedge com_clk);
      chk($sformatf("hunt%0d_pop_k%0d", lock_at, k), 16'(fifo_pop),
          (k == lock_at) ? 16'h0 : 16'h4);
      chk($sformatf("hunt%0d_cnt_k%0d", lock_at, k), hunt_cnt, 16'(k));
      chk($sformatf("hunt%0d_err_k%0d", lock_at, k), 16'(align_err), 16'h0);
      tick();
    end
    @(negedge com_clk);
    chk($sformatf("hunt%0d_end_err", lock_at), 16'(align_err), (lock_at < 0) ? 16'h1 : 16'h0);
    chk($sformatf("hunt%0d_end_done", lock_at), 16'(align_done), (lock_at < 0) ? 16'h0 : 16'h1);
    chk($sformatf("hunt%0d_end_cnt", lock_at), hunt_cnt, 16'd20);
    chk($sformatf("hunt%0d_end_pop", lock_at), 16'(fifo_pop), 16'h0);
    tick();
    align_en = 1'b0;
    tick();
    @(negedge com_clk);
    chk($sformatf("hunt%0d_idle_err", lock_at), 16'(align_err), 16'h0);
    chk($sformatf("hunt%0d_idle_done", lock_at), 16'(align_done), 16'h0);
    chk($sformatf("hunt%0d_idle_cnt", lock_at), hunt_cnt, 16'h0);
    tick();
  endtask

  // IDLE, four FILL cycles and one HUNT cycle with every head already a marker.
  task automatic go_locked();
    align_en = 1'b0; rd_en = 1'b0; rd_empty = 4'b0000; rx_marker = 4'b1111;
    tick();
    align_en = 1'b1;
    repeat (6) tick();
    @(negedge com_clk);
    chk("lock_done", 16'(align_done), 16'h1);
    tick();
  endtask

  task automatic run_skew(input int n, input logic expect_err);
    go_locked();
    rd_en = 1'b1; rx_marker = 4'b0000; rd_empty = 4'b0010;
    for (int c = 0; c < n; c++) begin
      @(negedge com_clk);
      chk($sformatf("skew%0d_pop_c%0d", n, c), 16'(fifo_pop), 16'h0);
      chk($sformatf("skew%0d_err_c%0d", n, c), 16'(align_err), 16'h0);
      tick();
    end
    rd_empty = 4'b0000;
    @(negedge com_clk);
    chk($sformatf("skew%0d_after_err", n), 16'(align_err), 16'(expect_err));
    chk($sformatf("skew%0d_after_pop", n), 16'(fifo_pop), expect_err ? 16'h0 : 16'hF);
    chk($sformatf("skew%0d_after_valid", n), 16'(rx_valid), expect_err ? 16'h0 : 16'h1);
    tick();
    @(negedge com_clk);
    chk($sformatf("skew%0d_later_err", n), 16'(align_err), 16'(expect_err));
    tick();
    align_en = 1'b0; rd_en = 1'b0;
    tick();
  endtask

  initial begin
    //           en    rd    empty    marker   pop      vld   done  err   hunt
    vecs[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[2]  = '{1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[3]  = '{1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[4]  = '{1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[5]  = '{1'b1, 1'b0, 4'b0000, 4'b0001, 4'b1110, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[6]  = '{1'b1, 1'b0, 4'b0000, 4'b0011, 4'b1100, 1'b0, 1'b0, 1'b0, 16'd1};
    vecs[7]  = '{1'b1, 1'b0, 4'b0000, 4'b0111, 4'b1000, 1'b0, 1'b0, 1'b0, 16'd2};
    vecs[8]  = '{1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd3};
    vecs[9]  = '{1'b1, 1'b1, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0, 16'd4};
    vecs[10] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0, 16'd4};
    vecs[11] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 16'd4};
    vecs[12] = '{1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 16'd4};
    vecs[13] = '{1'b1, 1'b1, 4'b0000, 4'b0101, 4'b1111, 1'b1, 1'b1, 1'b0, 16'd4};
    vecs[14] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 16'd4};
    vecs[15] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 16'd4};
    vecs[16] = '{1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0};

    rst_com_n = 1'b0; align_en = 1'b0; rd_en = 1'b0;
    rd_empty = 4'b1111; rx_marker = 4'b0000;
    repeat (2) @(posedge com_clk);
    @(negedge com_clk);
    chk("rst_pop", 16'(fifo_pop), 16'h0);
    chk("rst_done", 16'(align_done), 16'h0);
    chk("rst_err", 16'(align_err), 16'h0);
    chk("rst_hunt", hunt_cnt, 16'h0);
    chk("rst_valid", 16'(rx_valid), 16'h0);
    tick();
    rst_com_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      align_en  = vecs[i].en;
      rd_en     = vecs[i].rd;
      rd_empty  = vecs[i].empty;
      rx_marker = vecs[i].marker;
      @(negedge com_clk);
      chk($sformatf("vec%0d_pop", i), 16'(fifo_pop), 16'(vecs[i].pop));
      chk($sformatf("vec%0d_valid", i), 16'(rx_valid), 16'(vecs[i].valid));
      chk($sformatf("vec%0d_done", i), 16'(align_done), 16'(vecs[i].done));
      chk($sformatf("vec%0d_err", i), 16'(align_err), 16'(vecs[i].err));
      chk($sformatf("vec%0d_hunt", i), hunt_cnt, vecs[i].hunt);
      tick();
    end

    run_hunt(-1);
    run_hunt(19);

    // Channel 1 drops out at fill count 2; hunting must wait four full cycles after refill.
    align_en = 1'b0; rd_en = 1'b0; rd_empty = 4'b0000; rx_marker = 4'b0000;
    tick();
    align_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      rd_empty = (c == 3) ? 4'b0010 : 4'b0000;
      @(negedge com_clk);
      chk($sformatf("fill_pre_pop%0d", c), 16'(fifo_pop), 16'h0);
      tick();
    end
    rd_empty = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      @(negedge com_clk);
      chk($sformatf("fill_refill_pop%0d", c), 16'(fifo_pop), (c == 4) ? 16'hF : 16'h0);
      tick();
    end
    align_en = 1'b0;
    tick();

    run_skew(15, 1'b0);
    run_skew(16, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
